// File: rtl/alu_mdu_ctrl_pkg.sv
// Shared encodings for the ALU decoder and the multiply/divide unit.
// Holds the ALU control codes, main-control aluop classes, R-type funct
// codes and the MDU sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALUCTL_AND  = 4'b0000;
    localparam logic [3:0] ALUCTL_OR   = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD  = 4'b0010;
    localparam logic [3:0] ALUCTL_SLL  = 4'b0011;
    localparam logic [3:0] ALUCTL_SRL  = 4'b0100;
    localparam logic [3:0] ALUCTL_NOR  = 4'b0101;
    localparam logic [3:0] ALUCTL_SUB  = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT  = 4'b1001;
    localparam logic [3:0] ALUCTL_SLTU = 4'b1010;
    localparam logic [3:0] ALUCTL_XOR  = 4'b1011;
    localparam logic [3:0] ALUCTL_LUI  = 4'b1101;
    localparam logic [3:0] ALUCTL_OP7  = 4'b1111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_AND   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;
    localparam logic [2:0] ALUOP_SLTU  = 3'b101;
    localparam logic [2:0] ALUOP_LUI   = 3'b110;
    localparam logic [2:0] ALUOP_OP7   = 3'b111;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/alu_mdu_ctrl_if.sv
// Bus between the main control / datapath and the ALU decoder + MDU.
// The control side drives the operation and operands; the unit returns
// decode results, MDU status and the HI/LO contents.
interface alu_mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       aluop;
    logic [5:0]       funct;
    logic             start;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [3:0]       alucontrol;
    logic             illegal;
    logic             mdu_busy;
    logic             mdu_done;
    logic             mdu_stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mfresult;

    modport master (
        output aluop, funct, start, srca, srcb,
        input  alucontrol, illegal, mdu_busy, mdu_done, mdu_stall, hi, lo, mfresult
    );

    modport slave (
        input  aluop, funct, start, srca, srcb,
        output alucontrol, illegal, mdu_busy, mdu_done, mdu_stall, hi, lo, mfresult
    );
endinterface

// File: rtl/alu_mdu_ctrl_mdu_core.sv
// Iterative multiply/divide unit with HI/LO registers.
// Signed operations run on magnitudes and fix the sign in a single FIXUP
// cycle; one product or quotient bit is produced per cycle.
module mdu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rtype,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi, p_lo, opnd;
    logic             div_op, neg_res, neg_rem;

    logic             is_mul, is_div, is_sgn, md_op, mdu_cls, accept, div_zero;
    logic             mt_hi, mt_lo;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_mul   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign is_div   = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign is_sgn   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign md_op    = rtype && (is_mul || is_div);
    assign mdu_cls  = md_op || (rtype && ((funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
                                          (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO)));
    assign busy     = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIXUP);
    assign done     = (state == ST_DONE);
    assign accept   = start && md_op && !busy;
    assign stall    = start && mdu_cls && busy;
    assign mt_hi    = start && rtype && (funct == FUNCT_MTHI) && !busy;
    assign mt_lo    = start && rtype && (funct == FUNCT_MTLO) && !busy;
    assign div_zero = (srcb == '0);

    assign abs_a = (is_sgn && srca[WIDTH-1]) ? -srca : srca;
    assign abs_b = (is_sgn && srcb[WIDTH-1]) ? -srcb : srcb;

    // p_hi doubles as the running partial product (multiply) and the
    // partial remainder (divide); p_lo holds multiplier / quotient bits.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    assign prod_fix = neg_res ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign quo_fix  = neg_res ? -p_lo : p_lo;
    assign rem_fix  = neg_rem ? -p_hi : p_hi;

    // Sequencer state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state: a new op may start from IDLE or DONE, divide by zero skips the iterations.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (is_mul)        state_next = ST_MUL;
                    else if (div_zero) state_next = ST_FIXUP;
                    else               state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: if (cnt == CNT_W'(1)) state_next = ST_FIXUP;
            ST_FIXUP:       state_next = ST_DONE;
            default:        state_next = ST_IDLE;
        endcase
    end

    // Operand latch, one shift-add / restoring step per cycle, sign fixup and HI/LO writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            opnd    <= '0;
            div_op  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_MUL: begin
                    p_hi <= mul_sum[WIDTH:1];
                    p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    cnt  <= cnt - CNT_W'(1);
                end
                ST_DIV: begin
                    p_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    p_lo <= {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    cnt  <= cnt - CNT_W'(1);
                end
                ST_FIXUP: begin
                    if (div_op) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase

            if (accept) begin
                cnt     <= CNT_W'(WIDTH);
                div_op  <= is_div;
                neg_res <= is_sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                neg_rem <= is_sgn && srca[WIDTH-1];
                p_hi    <= '0;
                if (is_mul) begin
                    p_lo <= abs_b;
                    opnd <= abs_a;
                end else if (div_zero) begin
                    p_hi    <= srca;
                    p_lo    <= '1;
                    opnd    <= '0;
                    neg_res <= 1'b0;
                    neg_rem <= 1'b0;
                end else begin
                    p_lo <= abs_a;
                    opnd <= abs_b;
                end
            end

            if (mt_hi) hi <= srca;
            if (mt_lo) lo <= srca;
        end
    end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decoder with an attached multiply/divide unit.
// Decode is purely combinational; the MDU sequences over many cycles and
// exposes busy/done/stall so the main control can hold in execute.
module alu_mdu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    alu_mdu_ctrl_if.slave bus
);
    logic rtype;

    assign rtype        = (bus.aluop == ALUOP_RTYPE);
    assign bus.mfresult = (bus.funct == FUNCT_MFHI) ? bus.hi : bus.lo;

    // aluop/funct to ALU control; unknown R-type funct flags illegal and falls back to add.
    always_comb begin
        bus.alucontrol = ALUCTL_ADD;
        bus.illegal    = 1'b0;
        case (bus.aluop)
            ALUOP_ADD:  bus.alucontrol = ALUCTL_ADD;
            ALUOP_AND:  bus.alucontrol = ALUCTL_AND;
            ALUOP_OR:   bus.alucontrol = ALUCTL_OR;
            ALUOP_SLT:  bus.alucontrol = ALUCTL_SLT;
            ALUOP_SLTU: bus.alucontrol = ALUCTL_SLTU;
            ALUOP_LUI:  bus.alucontrol = ALUCTL_LUI;
            ALUOP_OP7:  bus.alucontrol = ALUCTL_OP7;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FUNCT_ADD, FUNCT_ADDU: bus.alucontrol = ALUCTL_ADD;
                    FUNCT_SUB, FUNCT_SUBU: bus.alucontrol = ALUCTL_SUB;
                    FUNCT_AND:             bus.alucontrol = ALUCTL_AND;
                    FUNCT_OR:              bus.alucontrol = ALUCTL_OR;
                    FUNCT_NOR:             bus.alucontrol = ALUCTL_NOR;
                    FUNCT_SLL:             bus.alucontrol = ALUCTL_SLL;
                    FUNCT_SRL:             bus.alucontrol = ALUCTL_SRL;
                    FUNCT_XOR:             bus.alucontrol = ALUCTL_XOR;
                    FUNCT_SLT:             bus.alucontrol = ALUCTL_SLT;
                    FUNCT_SLTU:            bus.alucontrol = ALUCTL_SLTU;
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                    FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO:
                                           bus.alucontrol = ALUCTL_ADD;
                    default:               bus.illegal    = 1'b1;
                endcase
            end
            default: bus.alucontrol = ALUCTL_ADD;
        endcase
    end

    mdu_core #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (bus.start),
        .rtype (rtype),
        .funct (bus.funct),
        .srca  (bus.srca),
        .srcb  (bus.srcb),
        .busy  (bus.mdu_busy),
        .done  (bus.mdu_done),
        .stall (bus.mdu_stall),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl: decode table points, MDU results,
// latency, divide-by-zero, overflow, stall, MT/MF, async reset, chaining.
module tb_alu_mdu_ctrl;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    alu_mdu_ctrl_if #(.WIDTH(32)) bus ();

    alu_mdu_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn, input logic st,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.aluop = op;
        bus.funct = fn;
        bus.start = st;
        bus.srca  = a;
        bus.srcb  = b;
    endtask

    // Present a start for one edge (edge 0); returns 1 unit into cycle 1.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        applyStimulus(3'b010, fn, 1'b1, a, b);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for mdu_done, checking the cycle it appears and the busy count before it.
    task automatic waitDone(input string tag, input int startCycle, input int expCycle);
        int c = startCycle;
        int busyCnt = 0;
        while (bus.mdu_done !== 1'b1 && c < startCycle + 100) begin
            if (bus.mdu_busy === 1'b1) busyCnt++;
            @(posedge clk); #1;
            c++;
        end
        if (bus.mdu_done !== 1'b1) begin
            checkOutput({tag, "_timeout"}, {31'b0, bus.mdu_done}, 32'd1);
        end else begin
            checkOutput({tag, "_donecyc"}, c, expCycle);
            checkOutput({tag, "_busycnt"}, busyCnt, expCycle - startCycle);
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(3'b000, 6'b000000, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, bus.mdu_busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus.mdu_done}, 32'd0);
        checkOutput("rst_hi", bus.hi, 32'h0);
        checkOutput("rst_lo", bus.lo, 32'h0);
        reset = 1'b1;

        applyStimulus(3'b000, 6'b000000, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_op000", bus.alucontrol, 32'h2);
        applyStimulus(3'b010, 6'b100010, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_sub", bus.alucontrol, 32'h6);
        checkOutput("dec_sub_ill", {31'b0, bus.illegal}, 32'd0);
        applyStimulus(3'b010, 6'b111111, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_bad_ill", {31'b0, bus.illegal}, 32'd1);
        checkOutput("dec_bad_ctl", bus.alucontrol, 32'h2);
        applyStimulus(3'b010, 6'b011010, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_div_ill", {31'b0, bus.illegal}, 32'd0);
        applyStimulus(3'b110, 6'b111111, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_op110", bus.alucontrol, 32'hD);
        checkOutput("dec_op110_ill", {31'b0, bus.illegal}, 32'd0);
        applyStimulus(3'b010, 6'b101011, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("dec_sltu", bus.alucontrol, 32'hA);

        issue(6'b011000, 32'hFFFFFFFD, 32'd7);
        checkOutput("mult_busy_c1", {31'b0, bus.mdu_busy}, 32'd1);
        waitDone("mult", 1, 34);
        checkOutput("mult_hi", bus.hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", bus.lo, 32'hFFFFFFEB);
        @(posedge clk); #1;
        checkOutput("mult_done_drop", {31'b0, bus.mdu_done}, 32'd0);

        issue(6'b011001, 32'hFFFFFFFF, 32'd2);
        waitDone("multu", 1, 34);
        checkOutput("multu_hi", bus.hi, 32'h1);
        checkOutput("multu_lo", bus.lo, 32'hFFFFFFFE);

        issue(6'b011011, 32'd100, 32'd7);
        waitDone("divu", 1, 34);
        checkOutput("divu_lo", bus.lo, 32'd14);
        checkOutput("divu_hi", bus.hi, 32'd2);

        issue(6'b011010, 32'hFFFFFFF9, 32'd2);
        waitDone("div_neg", 1, 34);
        checkOutput("div_neg_lo", bus.lo, 32'hFFFFFFFD);
        checkOutput("div_neg_hi", bus.hi, 32'hFFFFFFFF);

        issue(6'b011010, 32'd5, 32'd0);
        waitDone("div0", 1, 2);
        checkOutput("div0_lo", bus.lo, 32'hFFFFFFFF);
        checkOutput("div0_hi", bus.hi, 32'd5);

        issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
        waitDone("div_ovf", 1, 34);
        checkOutput("div_ovf_lo", bus.lo, 32'h80000000);
        checkOutput("div_ovf_hi", bus.hi, 32'h0);

        issue(6'b011000, 32'd3, 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        applyStimulus(3'b010, 6'b010011, 1'b1, 32'h1234, 32'h0); #1;
        checkOutput("stall_on", {31'b0, bus.mdu_stall}, 32'd1);
        @(posedge clk); #1;
        checkOutput("stall_lo_kept", bus.lo, 32'h80000000);
        checkOutput("stall_busy", {31'b0, bus.mdu_busy}, 32'd1);
        bus.start = 1'b0; #1;
        checkOutput("stall_off", {31'b0, bus.mdu_stall}, 32'd0);
        waitDone("mult_stall", 6, 34);
        checkOutput("mult_stall_lo", bus.lo, 32'd15);
        checkOutput("mult_stall_hi", bus.hi, 32'd0);

        @(posedge clk); #1;
        applyStimulus(3'b010, 6'b010011, 1'b1, 32'h1234, 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("mtlo_lo", bus.lo, 32'h1234);
        checkOutput("mtlo_nodone", {31'b0, bus.mdu_done}, 32'd0);
        applyStimulus(3'b010, 6'b010010, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("mflo", bus.mfresult, 32'h1234);
        @(posedge clk); #1;
        applyStimulus(3'b010, 6'b010001, 1'b1, 32'hABCD, 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        applyStimulus(3'b010, 6'b010000, 1'b0, 32'h0, 32'h0); #1;
        checkOutput("mfhi", bus.mfresult, 32'hABCD);

        issue(6'b011000, 32'h10, 32'h20);
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, bus.mdu_busy}, 32'd0);
        checkOutput("arst_hi", bus.hi, 32'h0);
        checkOutput("arst_lo", bus.lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        checkOutput("arst_idle", {31'b0, bus.mdu_busy}, 32'd0);

        issue(6'b011000, 32'd6, 32'd7);
        waitDone("mult_post", 1, 34);
        checkOutput("mult_post_lo", bus.lo, 32'd42);
        checkOutput("mult_post_hi", bus.hi, 32'd0);

        issue(6'b011001, 32'd3, 32'd3);
        waitDone("b2b_a", 1, 34);
        checkOutput("b2b_a_lo", bus.lo, 32'd9);
        applyStimulus(3'b010, 6'b011011, 1'b1, 32'd100, 32'd10);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("b2b_busy", {31'b0, bus.mdu_busy}, 32'd1);
        waitDone("b2b_b", 1, 34);
        checkOutput("b2b_b_lo", bus.lo, 32'd10);
        checkOutput("b2b_b_hi", bus.hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
